// File: rtl/ot_receiver_pkg.sv
// Shared types and constants for the OT receiver and its mod_exp engine.
package ot_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned RX1_BYTES = 16;
    localparam int unsigned TX_BYTES  = 4;
    localparam int unsigned RX2_BYTES = 8;

    localparam logic [WORD_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        IDLE, RECV1, RED_K, EXP, RED_X, ADD, SEND, RECV2, RED_C, SUB
    } ot_state_e;

    typedef enum logic [2:0] {
        ME_IDLE, ME_RED, ME_BIT, ME_SQ, ME_MUL
    } me_state_e;

    // One step of the 32-bit Galois key LFSR.
    function automatic word_t lfsr_next(input word_t s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/ot_receiver_if.sv
// Byte links between the OT receiver and the sender (rx: sender->receiver, tx: receiver->sender).
interface ot_receiver_if;

    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data
    );

endinterface

// File: rtl/ot_receiver_mod_exp.sv
// Sequential modular exponentiation: base is first reduced, then MSB-first square-and-multiply.
module mod_exp
    import ot_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  go,
    input  word_t base,
    input  word_t exp,
    input  word_t mod,
    output word_t result,
    output logic  done
);

    me_state_e   state;
    word_t       base_r;
    word_t       res;
    word_t       ebits;
    word_t       mm_a;
    word_t       mm_b;
    word_t       acc;
    logic [5:0]  bit_cnt;
    logic [4:0]  mm_cnt;
    logic        one_flag;
    logic        mul_pend;

    logic [32:0] dbl;
    logic [32:0] dbl_red;
    logic [33:0] add;
    word_t       step_c;
    word_t       one_mod;

    // One interleaved shift-add-subtract step of acc = (2*acc + b_msb*a) mod n; needs a < n.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, mod}) ? dbl - {1'b0, mod} : dbl;
        add     = {1'b0, dbl_red} + (mm_b[WORD_W-1] ? {2'b00, mm_a} : 34'd0);
        step_c  = (add >= {2'b00, mod}) ? WORD_W'(add - {2'b00, mod}) : WORD_W'(add);
        one_mod = WORD_W'(mod != WORD_W'(1));
    end

    // Engine sequencer; a leading-one flag skips squaring while the accumulator is still 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ME_IDLE;
            base_r   <= '0;
            res      <= '0;
            ebits    <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            mm_cnt   <= '0;
            one_flag <= 1'b0;
            mul_pend <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ME_IDLE: begin
                    if (go) begin
                        ebits    <= exp;
                        bit_cnt  <= '0;
                        one_flag <= 1'b1;
                        mul_pend <= 1'b0;
                        mm_a     <= WORD_W'(1);
                        mm_b     <= base;
                        acc      <= '0;
                        mm_cnt   <= '0;
                        state    <= ME_RED;
                    end
                end
                ME_RED: begin
                    acc    <= step_c;
                    mm_b   <= mm_b << 1;
                    mm_cnt <= mm_cnt + 5'd1;
                    if (mm_cnt == 5'd31) begin
                        base_r <= step_c;
                        state  <= ME_BIT;
                    end
                end
                ME_BIT: begin
                    if (bit_cnt == 6'd32) begin
                        result <= one_flag ? one_mod : res;
                        done   <= 1'b1;
                        state  <= ME_IDLE;
                    end else begin
                        ebits   <= ebits << 1;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (one_flag) begin
                            if (ebits[WORD_W-1]) begin
                                res      <= base_r;
                                one_flag <= 1'b0;
                            end
                        end else begin
                            mm_a     <= res;
                            mm_b     <= res;
                            acc      <= '0;
                            mm_cnt   <= '0;
                            mul_pend <= ebits[WORD_W-1];
                            state    <= ME_SQ;
                        end
                    end
                end
                ME_SQ: begin
                    acc    <= step_c;
                    mm_b   <= mm_b << 1;
                    mm_cnt <= mm_cnt + 5'd1;
                    if (mm_cnt == 5'd31) begin
                        res <= step_c;
                        if (mul_pend) begin
                            mm_a   <= base_r;
                            mm_b   <= step_c;
                            acc    <= '0;
                            mm_cnt <= '0;
                            state  <= ME_MUL;
                        end else begin
                            state <= ME_BIT;
                        end
                    end
                end
                ME_MUL: begin
                    acc    <= step_c;
                    mm_b   <= mm_b << 1;
                    mm_cnt <= mm_cnt + 5'd1;
                    if (mm_cnt == 5'd31) begin
                        res   <= step_c;
                        state <= ME_BIT;
                    end
                end
                default: state <= ME_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ot_receiver.sv
// Receiver side of 1-out-of-2 RSA oblivious transfer over byte links.
module ot_receiver
    import ot_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2025
)
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          choice,
    ot_receiver_if.slave  link,
    output word_t         msg_out,
    output logic          msg_valid,
    output logic          busy,
    output logic          err
);

    ot_state_e        state;
    word_t            lfsr;
    logic             choice_q;
    logic [IDX_W-1:0] idx;
    logic [23:0]      word_sr;
    logic [23:0]      v_sr;
    word_t            n_q;
    word_t            e_q;
    word_t            x_q;
    word_t            k_q;
    word_t            r_q;
    word_t            t_q;
    word_t            c_q;

    logic             me_go;
    word_t            me_base;
    word_t            me_exp;
    word_t            me_result;
    logic             me_done;

    logic             rx_fire;
    logic             tx_fire;
    word_t            rx_word;
    word_t            k_red;
    logic [32:0]      sum33;
    word_t            v_sum;
    word_t            m_val;

    mod_exp u_mod_exp (
        .clk    (clk),
        .rstn   (rstn),
        .go     (me_go),
        .base   (me_base),
        .exp    (me_exp),
        .mod    (n_q),
        .result (me_result),
        .done   (me_done)
    );

    // Handshake qualifiers, word assembly and the single-cycle ADD/SUB arithmetic.
    always_comb begin
        rx_fire = link.rx_valid && link.rx_ready;
        tx_fire = link.tx_valid && link.tx_ready;
        rx_word = {link.rx_data, word_sr};
        k_red   = (me_result == '0) ? WORD_W'(1) : me_result;
        sum33   = {1'b0, t_q} + {1'b0, r_q};
        v_sum   = (sum33 >= {1'b0, n_q}) ? WORD_W'(sum33 - {1'b0, n_q}) : WORD_W'(sum33);
        m_val   = (c_q >= k_q) ? c_q - k_q : (n_q - k_q) + c_q;
    end

    // Session FSM with registered outputs; issues one mod_exp job per compute state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            lfsr          <= LFSR_SEED;
            choice_q      <= 1'b0;
            idx           <= '0;
            word_sr       <= '0;
            v_sr          <= '0;
            n_q           <= '0;
            e_q           <= '0;
            x_q           <= '0;
            k_q           <= '0;
            r_q           <= '0;
            t_q           <= '0;
            c_q           <= '0;
            me_go         <= 1'b0;
            me_base       <= '0;
            me_exp        <= '0;
            link.rx_ready <= 1'b0;
            link.tx_valid <= 1'b0;
            link.tx_data  <= '0;
            msg_out       <= '0;
            msg_valid     <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            lfsr      <= lfsr_next(lfsr);
            me_go     <= 1'b0;
            msg_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        choice_q      <= choice;
                        idx           <= '0;
                        link.rx_ready <= 1'b1;
                        busy          <= 1'b1;
                        state         <= RECV1;
                    end
                end
                RECV1: begin
                    if (rx_fire) begin
                        idx     <= idx + IDX_W'(1);
                        word_sr <= rx_word[31:8];
                        if (idx[1:0] == 2'd3) begin
                            case (idx[3:2])
                                2'd0: n_q <= rx_word;
                                2'd1: e_q <= rx_word;
                                2'd2: if (!choice_q) x_q <= rx_word;
                                2'd3: if (choice_q)  x_q <= rx_word;
                            endcase
                        end
                        if (idx == IDX_W'(RX1_BYTES - 1)) begin
                            link.rx_ready <= 1'b0;
                            idx           <= '0;
                            if (n_q < WORD_W'(2)) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                me_base <= lfsr;
                                me_exp  <= WORD_W'(1);
                                me_go   <= 1'b1;
                                state   <= RED_K;
                            end
                        end
                    end
                end
                RED_K: begin
                    if (me_done) begin
                        k_q     <= k_red;
                        me_base <= k_red;
                        me_exp  <= e_q;
                        me_go   <= 1'b1;
                        state   <= EXP;
                    end
                end
                EXP: begin
                    if (me_done) begin
                        r_q     <= me_result;
                        me_base <= x_q;
                        me_exp  <= WORD_W'(1);
                        me_go   <= 1'b1;
                        state   <= RED_X;
                    end
                end
                RED_X: begin
                    if (me_done) begin
                        t_q   <= me_result;
                        state <= ADD;
                    end
                end
                ADD: begin
                    link.tx_data  <= v_sum[7:0];
                    v_sr          <= v_sum[31:8];
                    link.tx_valid <= 1'b1;
                    idx           <= '0;
                    state         <= SEND;
                end
                SEND: begin
                    if (tx_fire) begin
                        if (idx == IDX_W'(TX_BYTES - 1)) begin
                            link.tx_valid <= 1'b0;
                            link.rx_ready <= 1'b1;
                            idx           <= '0;
                            state         <= RECV2;
                        end else begin
                            link.tx_data <= v_sr[7:0];
                            v_sr         <= {8'h00, v_sr[23:8]};
                            idx          <= idx + IDX_W'(1);
                        end
                    end
                end
                RECV2: begin
                    if (rx_fire) begin
                        idx     <= idx + IDX_W'(1);
                        word_sr <= rx_word[31:8];
                        if (idx[1:0] == 2'd3 && idx[2] == choice_q) begin
                            c_q <= rx_word;
                        end
                        if (idx == IDX_W'(RX2_BYTES - 1)) begin
                            link.rx_ready <= 1'b0;
                            idx           <= '0;
                            me_base       <= choice_q ? rx_word : c_q;
                            me_exp        <= WORD_W'(1);
                            me_go         <= 1'b1;
                            state         <= RED_C;
                        end
                    end
                end
                RED_C: begin
                    if (me_done) begin
                        c_q   <= me_result;
                        state <= SUB;
                    end
                end
                SUB: begin
                    msg_out   <= m_val;
                    msg_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ot_receiver.md
Name: ot_receiver

Overview:
- Receiver side of 1-out-of-2 RSA oblivious transfer. It is the byte-stream peer of the OT sender, connected through the UART byte links.
- Flow: takes N, e, x0 and x1 from the sender, blinds x_choice with k^e, and returns v. It then takes the two packed ciphertexts and recovers m_choice = (c_choice − k) mod N.
- Compute engine is one shared sequential modular-exponentiation sub-module.

Parameters:
- LFSR_SEED, 32'hACE1_2025, non-zero reset seed of the internal key LFSR.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  pulse: begin one OT session; ignored unless in IDLE
- choice  in  1  selection bit b; sampled on accepted start
- rx_valid  in  1  byte available from sender link
- rx_ready  out  1  receiver accepts byte
- rx_data  in  8  incoming byte
- tx_valid  out  1  byte offered to sender link
- tx_ready  in  1  link accepts byte
- tx_data  out  8  outgoing byte
- msg_out  out  32  recovered message m_b
- msg_valid  out  1  one-cycle pulse when msg_out updates
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on aborted session

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, LFSR=LFSR_SEED, all outputs 0, byte index 0. Applies from any state; a partially received word is discarded.
- Handshakes: rx byte transfers when rx_valid&&rx_ready; tx byte transfers when tx_valid&&tx_ready.
  - rx_ready is high only in RECV1 and RECV2.
  - Once tx_valid is raised, tx_valid and tx_data hold until accepted.
  - Next byte is offered the cycle after acceptance; no bubble is required.
- Byte order: all 32-bit words are little-endian, LSB byte first.
- LFSR: 32-bit Galois, taps 32'h8020_0003. Advances every cycle outside reset. Its value is captured as raw k when RECV1 completes.
- States:
  - IDLE: on start, latch choice, index=0, go to RECV1.
  - RECV1: accept 16 bytes: N, e, x0, x1. After byte 15, if N<2, pulse err and go to IDLE; else go to RED_K.
  - RED_K: k = raw_k mod N, computed as mod_exp(raw_k, 1, N). If result is 0, force k=1.
  - EXP: r = k^e mod N.
  - RED_X: t = x_b mod N, via mod_exp(x_b, 1, N).
  - ADD: v = t+r; if v ≥ N then v = v−N. Use a 33-bit sum. Single cycle.
  - SEND: transmit 4 bytes of v, then go to RECV2 with index 0.
  - RECV2: accept 8 bytes c0, c1. Keep only c_b.
  - RED_C: c = c_b mod N.
  - SUB: m = (c ≥ k) ? c−k : c+N−k. Drive msg_out=m, pulse msg_valid, go to IDLE.
- mod_exp handshake: go pulse; done pulse ≥1 cycle later; result held until next go. The top issues go only when the sub-module is idle.
- mod_exp results: exp=0 → 1 mod N. Outputs are always < N.
- start while busy: ignored.
- rx_valid outside RECV1/RECV2: not consumed.
- msg_out holds its value until the next successful session or reset.

Decomposition:
- Package ot_pkg holds:
  - state enum (IDLE, RECV1, RED_K, EXP, RED_X, ADD, SEND, RECV2, RED_C, SUB)
  - byte counts RX1_BYTES=16, TX_BYTES=4, RX2_BYTES=8
  - LFSR tap constant
  - word width 32
- Sub-module mod_exp:
  - ports clk, rstn, go, base[31:0], exp[31:0], mod[31:0], result[31:0], done
  - Square-and-multiply, MSB-first over 32 exponent bits.
  - Each modmul is an interleaved shift-add-subtract over 32 cycles with 33/34-bit intermediates.
  - No DSP requirement.

Test Plan:
- Bench plays sender with N=128255609, e=17, d=75431153, x0/x1 from sender PRNG, m0=12345, m1=67890. It computes c_i = m_i + (v−x_i)^d mod N. With choice=0 → msg_out=12345 with one msg_valid pulse; choice=1 → msg_out=67890.
- Small-modulus sweep: N=33, e=3, d=7, m0=5, m1=9, x0=40, x1=7 (x0 ≥ N exercises reduction). Both choices, 50 LFSR phases → recovered value always equals m_b.
- Backpressure: tx_ready toggles 1-0-0-1 randomly; rx_valid has random gaps. Expect:
  - v bytes unchanged while stalled.
  - exactly 4 tx transfers.
  - identical result to the no-stall run.
- N=1 in RECV1 → err pulses one cycle after byte 15; no tx_valid; busy falls; msg_valid never asserted.
- Start asserted during EXP and mid-SEND → ignored; session output unchanged.
- rstn low for one cycle during RECV2 (byte 3), then a fresh session with N=33 → outputs zero after reset; second session returns the correct m_b.
